// File: rtl/ac_scan_seq.sv
// ac_scan_seq
//   Time-shares the single analog comparator across NCH multiplexed inputs.
//   Each enabled channel is visited in ascending order: the mux is pointed at
//   it, the comparator is held enabled for a settle period, then NSAMP samples
//   of acout are taken and majority-voted into that channel's result bit.
//   Any result bit that flips raises a sticky irq.
//
// Ports
//   clk, rst   system clock, asynchronous active-high reset
//   start      1-cycle pulse to begin a scan (ignored while busy)
//   cont       rescan automatically after each scan while set
//   chen       channel enable mask, latched at each scan start
//   settle     settle cycles per channel, sampled on entry to each channel (0 acts as 1)
//   irq_clr    clears irq unless a result change happens in the same cycle
//   acout      synchronised comparator output
//   acenable   comparator enable
//   acsel      comparator input mux select
//   busy       scan in progress
//   result     latest majority result, one bit per channel
//   done       1-cycle pulse at the end of every scan
//   irq        sticky result-change flag
module ac_scan_seq #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned SETTLE_W = 8,
  parameter int unsigned NSAMP    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      cont,
  input  logic [NCH-1:0]            chen,
  input  logic [SETTLE_W-1:0]       settle,
  input  logic                      irq_clr,
  input  logic                      acout,
  output logic                      acenable,
  output logic [$clog2(NCH)-1:0]    acsel,
  output logic                      busy,
  output logic [NCH-1:0]            result,
  output logic                      done,
  output logic                      irq
);

  localparam int unsigned SW = $clog2(NCH);
  localparam int unsigned CW = $clog2(NSAMP + 1);
  localparam logic [CW-1:0] LAST = CW'(NSAMP - 1);
  localparam logic [CW-1:0] HALF = CW'(NSAMP / 2);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, NEXT} state_t;

  state_t              state;
  logic [NCH-1:0]      mask_q;
  logic [SETTLE_W-1:0] setcnt;
  logic [CW-1:0]       smpcnt;
  logic [CW-1:0]       ones;

  // Lowest set bit of m at or above index lo; MSB of the return is "found".
  function automatic logic [SW:0] find_from(input logic [NCH-1:0] m,
                                            input int unsigned lo);
    logic [SW:0] r;
    r = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!r[SW] && m[i] && (i >= lo)) begin
        r = {1'b1, SW'(i)};
      end
    end
    return r;
  endfunction

  logic [SW:0]         first_hit;
  logic [SW:0]         next_hit;
  logic [SETTLE_W-1:0] settle_ld;
  logic [CW-1:0]       ones_tot;
  logic                last_smp;
  logic                new_bit;
  logic                irq_set;

  always_comb begin
    first_hit = find_from(chen, 0);
    next_hit  = find_from(mask_q, 32'(acsel) + 32'd1);
    settle_ld = (settle == '0) ? SETTLE_W'(1) : settle;
    // include the sample being taken this cycle in the vote
    ones_tot  = ones + CW'(acout);
    last_smp  = (state == SAMPLE) && (smpcnt == LAST);
    new_bit   = (ones_tot > HALF);
    irq_set   = last_smp && (new_bit != result[acsel]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mask_q   <= '0;
      setcnt   <= '0;
      smpcnt   <= '0;
      ones     <= '0;
      acenable <= 1'b0;
      acsel    <= '0;
      busy     <= 1'b0;
      result   <= '0;
      done     <= 1'b0;
      irq      <= 1'b0;
    end else begin
      done <= 1'b0;

      // a change event takes priority over a simultaneous clear
      if (irq_set) begin
        irq <= 1'b1;
      end else if (irq_clr) begin
        irq <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            mask_q <= chen;
            if (!first_hit[SW]) begin
              done <= 1'b1;
            end else begin
              acsel    <= first_hit[SW-1:0];
              setcnt   <= settle_ld;
              busy     <= 1'b1;
              acenable <= 1'b1;
              state    <= SETTLE;
            end
          end
        end

        SETTLE: begin
          if (setcnt <= SETTLE_W'(1)) begin
            smpcnt <= '0;
            ones   <= '0;
            state  <= SAMPLE;
          end else begin
            setcnt <= setcnt - SETTLE_W'(1);
          end
        end

        SAMPLE: begin
          if (last_smp) begin
            result[acsel] <= new_bit;
            state         <= NEXT;
          end else begin
            smpcnt <= smpcnt + CW'(1);
            ones   <= ones_tot;
          end
        end

        NEXT: begin
          if (next_hit[SW]) begin
            acsel  <= next_hit[SW-1:0];
            setcnt <= settle_ld;
            state  <= SETTLE;
          end else begin
            done <= 1'b1;
            if (cont) begin
              mask_q <= chen;
            end
            if (cont && first_hit[SW]) begin
              acsel  <= first_hit[SW-1:0];
              setcnt <= settle_ld;
              state  <= SETTLE;
            end else begin
              busy     <= 1'b0;
              acenable <= 1'b0;
              state    <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
